multicycle_control_unit: RTL and testbench

- Next-generation MIPS control for the multicycle datapath: replaces the combinational single-cycle decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Adds memory wait handshakes (ihit/dhit), a parametrised memory-stall watchdog, LL/SC link tracking and illegal-opcode handling.
- Sits between the instruction register and the datapath muxes. All opcode, funct and aluop_t encodings come from cpu_types_pkg.

---
 rtl/cpu_types_pkg.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared MIPS encodings: opcodes, R-type funct codes and ALU operations.
package cpu_types_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath: fetch/decode/execute/mem/writeback
// sequencing with memory handshakes, a stall watchdog and LL/SC link tracking.
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT   = 64,
    parameter int unsigned ATOMICS      = 1,
    parameter int unsigned TRAP_ILLEGAL = 0,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       link_inv,
    output logic       iREN,
    output logic       dREN,
    output logic       dWEN,
    output logic       IRWr,
    output logic       PCWr,
    output logic       PCSrc,
    output logic       jump,
    output logic       jr,
    output logic       jal,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrc,
    output logic       ExtOp,
    output aluop_t     ALUop,
    output logic       mem2reg,
    output logic       lui,
    output logic       sc_wr,
    output logic       sc_ok,
    output logic       halt,
    output logic       mem_err,
    output logic       illegal
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] EXEC   = 4'd2;
    localparam logic [3:0] ADDR   = 4'd3;
    localparam logic [3:0] MEM    = 4'd4;
    localparam logic [3:0] WB     = 4'd5;
    localparam logic [3:0] BRANCH = 4'd6;
    localparam logic [3:0] JUMP   = 4'd7;
    localparam logic [3:0] HALTED = 4'd8;

    // Trip when the count of earlier unacked cycles reaches WAIT_LIMIT-1, i.e. on the
    // WAIT_LIMIT-th consecutive unacknowledged cycle.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [3:0]       state_q, state_d, dec_next;
    logic [5:0]       op_q, fn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             link_q, link_d, sc_ok_q, err_q;
    logic             dec_illegal;
    logic             is_rtype, is_load, is_sw, is_sc, is_ialu, sc_can;
    logic             waiting, wd_trip;
    aluop_t           ex_op;
    logic [1:0]       ex_src;
    logic             ex_ext;

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_load  = (op_q == OP_LW) || (op_q == OP_LL);
    assign is_sw    = (op_q == OP_SW);
    assign is_sc    = (op_q == OP_SC);
    assign is_ialu  = (op_q >= OP_ADDI) && (op_q <= OP_XORI);
    // An invalidate in the same cycle as the SC is sampled kills the store.
    assign sc_can   = link_q && !link_inv;

    assign waiting = ((state_q == FETCH) && !ihit) ||
                     ((state_q == MEM) && (is_load || is_sw || (is_sc && sc_can)) && !dhit);
    assign wd_trip = (WAIT_LIMIT != 0) && waiting && (cnt_q >= LIMIT_M1);

    // Instruction-class decode of the live IR fields, used only in DECODE
    always_comb begin
        dec_next    = FETCH;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: dec_next = EXEC;
                    FN_JR:                           dec_next = JUMP;
                    default:                         dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: dec_next = EXEC;
            OP_LW, OP_SW:   dec_next = ADDR;
            OP_LL, OP_SC: begin
                if (ATOMICS != 0) dec_next = ADDR;
                else              dec_illegal = 1'b1;
            end
            OP_BEQ, OP_BNE: dec_next = BRANCH;
            OP_J, OP_JAL:   dec_next = JUMP;
            OP_LUI:         dec_next = WB;
            OP_HALT:        dec_next = HALTED;
            default:        dec_illegal = 1'b1;
        endcase
        if (dec_illegal) dec_next = (TRAP_ILLEGAL != 0) ? HALTED : FETCH;
    end

    // ALU controls for ALU-class instructions, from the registered opcode/funct
    always_comb begin
        ex_op  = ALU_SLL;
        ex_src = 2'b00;
        ex_ext = 1'b0;
        if (is_rtype) begin
            case (fn_q)
                FN_SLL:          ex_src = 2'b01;
                FN_SRL:          begin ex_op = ALU_SRL; ex_src = 2'b01; end
                FN_ADD, FN_ADDU: ex_op = ALU_ADD;
                FN_SUB, FN_SUBU: ex_op = ALU_SUB;
                FN_AND:          ex_op = ALU_AND;
                FN_OR:           ex_op = ALU_OR;
                FN_XOR:          ex_op = ALU_XOR;
                FN_NOR:          ex_op = ALU_NOR;
                FN_SLT:          ex_op = ALU_SLT;
                FN_SLTU:         ex_op = ALU_SLTU;
                default:         ;
            endcase
        end else begin
            case (op_q)
                OP_ADDI, OP_ADDIU: begin ex_op = ALU_ADD;  ex_src = 2'b10; ex_ext = 1'b1; end
                OP_SLTI:           begin ex_op = ALU_SLT;  ex_src = 2'b10; ex_ext = 1'b1; end
                OP_SLTIU:          begin ex_op = ALU_SLTU; ex_src = 2'b10; ex_ext = 1'b1; end
                OP_ANDI:           begin ex_op = ALU_AND;  ex_src = 2'b10; end
                OP_ORI:            begin ex_op = ALU_OR;   ex_src = 2'b10; end
                OP_XORI:           begin ex_op = ALU_XOR;  ex_src = 2'b10; end
                default:           ;
            endcase
        end
    end

    // Next state, watchdog counter and LL link
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (wd_trip) state_d = HALTED; else if (ihit) state_d = DECODE;
            DECODE: state_d = dec_next;
            EXEC:   state_d = WB;
            ADDR:   state_d = MEM;
            MEM: begin
                if (wd_trip)                   state_d = HALTED;
                else if (is_load)              state_d = dhit ? WB : MEM;
                else if (is_sw)                state_d = dhit ? FETCH : MEM;
                else if (is_sc && sc_can)      state_d = dhit ? WB : MEM;
                else if (is_sc)                state_d = WB;
                else                           state_d = FETCH;
            end
            WB, BRANCH, JUMP: state_d = FETCH;
            HALTED:           state_d = HALTED;
            default:          state_d = FETCH;
        endcase

        if (!waiting)             cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + 1'b1;

        link_d = link_q;
        if (link_inv)                                                 link_d = 1'b0;
        else if ((state_q == MEM) && is_sc && (state_d != MEM))       link_d = 1'b0;
        else if ((state_q == MEM) && (op_q == OP_LL) && dhit)         link_d = 1'b1;
    end

    // State and bookkeeping registers; opcode/funct captured while in DECODE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
            link_q  <= 1'b0;
            sc_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            link_q  <= link_d;
            err_q   <= err_q | wd_trip;
            if (state_q == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if ((state_q == MEM) && is_sc) sc_ok_q <= sc_can;
        end
    end

    // Moore output decode; everything forced low while reset is held
    always_comb begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; IRWr = 1'b0; PCWr = 1'b0;
        PCSrc = 1'b0; jump = 1'b0; jr = 1'b0; jal = 1'b0; RegWr = 1'b0;
        RegDst = 2'b00; ALUSrc = 2'b00; ExtOp = 1'b0; ALUop = ALU_SLL;
        mem2reg = 1'b0; lui = 1'b0; sc_wr = 1'b0; sc_ok = 1'b0;
        halt = 1'b0; mem_err = 1'b0; illegal = 1'b0;
        if (!RST) begin
            case (state_q)
                FETCH: begin
                    iREN = 1'b1;
                    IRWr = ihit;
                    PCWr = ihit;
                end
                DECODE: illegal = dec_illegal;
                EXEC: begin
                    ALUop = ex_op; ALUSrc = ex_src; ExtOp = ex_ext;
                end
                // Address controls stay up for the whole access so the address is stable.
                ADDR, MEM: begin
                    ALUop = ALU_ADD; ALUSrc = 2'b10; ExtOp = 1'b1;
                    if (state_q == MEM) begin
                        dREN = is_load;
                        dWEN = is_sw || (is_sc && sc_can);
                    end
                end
                WB: begin
                    RegWr   = 1'b1;
                    RegDst  = is_rtype ? 2'b01 : 2'b00;
                    mem2reg = is_load;
                    lui     = (op_q == OP_LUI);
                    sc_wr   = is_sc;
                    sc_ok   = is_sc && sc_ok_q;
                    // No ALU output register: the result is written straight from the ALU.
                    if (is_rtype || is_ialu) begin
                        ALUop = ex_op; ALUSrc = ex_src; ExtOp = ex_ext;
                    end
                end
                BRANCH: begin
                    ALUop = ALU_SUB;
                    PCSrc = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                    PCWr  = PCSrc;
                end
                JUMP: begin
                    PCWr = 1'b1;
                    if (op_q == OP_JAL) begin
                        jump = 1'b1; jal = 1'b1; RegWr = 1'b1; RegDst = 2'b10;
                    end else if (is_rtype) begin
                        jr = 1'b1;
                    end else begin
                        jump = 1'b1;
                    end
                end
                HALTED:  halt = 1'b1;
                default: ;
            endcase
            mem_err = err_q;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected output vectors go through a
// scoreboard queue; a second instance with a short watchdog exercises the stall path.
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic       iren, dren, dwen, irwr, pcwr, pcsrc, jump, jr, jal, regwr;
        logic [1:0] regdst, alusrc;
        logic       extop;
        logic [3:0] aluop;
        logic       mem2reg, lui, sc_wr, sc_ok, halt, mem_err, illegal;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } sb_item_t;

    logic       CLK = 1'b0;
    logic       RST, zero, ihit, dhit, link_inv, wd_rst, wd_ihit;
    logic [5:0] opcode, funct;

    logic       iREN, dREN, dWEN, IRWr, PCWr, PCSrc, jump, jr, jal, RegWr;
    logic [1:0] RegDst, ALUSrc;
    logic       ExtOp, mem2reg, lui, sc_wr, sc_ok, halt, mem_err, illegal;
    aluop_t     ALUop;

    logic       w_iren, w_dren, w_dwen, w_irwr, w_pcwr, w_pcsrc, w_jump, w_jr, w_jal, w_regwr;
    logic [1:0] w_regdst, w_alusrc;
    logic       w_extop, w_mem2reg, w_lui, w_sc_wr, w_sc_ok, w_halt, w_mem_err, w_illegal;
    aluop_t     w_aluop;

    int         n_checks = 0;
    int         n_fail   = 0;
    sb_item_t   sb[$];
    out_t       act;

    always #5 CLK = ~CLK;

    multicycle_control_unit dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero), .ihit(ihit),
        .dhit(dhit), .link_inv(link_inv), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .jump(jump), .jr(jr), .jal(jal),
        .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUop(ALUop),
        .mem2reg(mem2reg), .lui(lui), .sc_wr(sc_wr), .sc_ok(sc_ok), .halt(halt),
        .mem_err(mem_err), .illegal(illegal)
    );

    multicycle_control_unit #(.WAIT_LIMIT(4), .CNT_W(3)) dut_wd (
        .CLK(CLK), .RST(wd_rst), .opcode(opcode), .funct(funct), .zero(zero),
        .ihit(wd_ihit), .dhit(dhit), .link_inv(link_inv), .iREN(w_iren), .dREN(w_dren),
        .dWEN(w_dwen), .IRWr(w_irwr), .PCWr(w_pcwr), .PCSrc(w_pcsrc), .jump(w_jump),
        .jr(w_jr), .jal(w_jal), .RegWr(w_regwr), .RegDst(w_regdst), .ALUSrc(w_alusrc),
        .ExtOp(w_extop), .ALUop(w_aluop), .mem2reg(w_mem2reg), .lui(w_lui),
        .sc_wr(w_sc_wr), .sc_ok(w_sc_ok), .halt(w_halt), .mem_err(w_mem_err),
        .illegal(w_illegal)
    );

    always_comb begin
        act = '{iren: iREN, dren: dREN, dwen: dWEN, irwr: IRWr, pcwr: PCWr, pcsrc: PCSrc,
                jump: jump, jr: jr, jal: jal, regwr: RegWr, regdst: RegDst, alusrc: ALUSrc,
                extop: ExtOp, aluop: ALUop, mem2reg: mem2reg, lui: lui, sc_wr: sc_wr,
                sc_ok: sc_ok, halt: halt, mem_err: mem_err, illegal: illegal};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compares the full output vector mid-cycle
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            sb_item_t it;
            it = sb.pop_front();
            check_eq(it.tag, 32'(act), 32'(it.exp));
        end
    end

    function automatic out_t fetch_hit();
        out_t e = '0;
        e.iren = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
        return e;
    endfunction

    function automatic out_t alu(input aluop_t op, input logic [1:0] src, input logic ext);
        out_t e = '0;
        e.aluop = op; e.alusrc = src; e.extop = ext;
        return e;
    endfunction

    task automatic cyc(input string tag, input out_t e);
        sb.push_back('{tag: tag, exp: e});
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic wcyc(input string tag, input out_t e, input logic wi, input logic wh,
                        input logic we);
        sb.push_back('{tag: tag, exp: e});
        @(negedge CLK);
        check_eq({tag, "_wd_iren"}, 32'(w_iren), 32'(wi));
        check_eq({tag, "_wd_halt"}, 32'(w_halt), 32'(wh));
        check_eq({tag, "_wd_err"}, 32'(w_mem_err), 32'(we));
        @(posedge CLK);
        #1;
    endtask

    task automatic fd(input string n, input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cyc({n, "_fetch"}, fetch_hit());
        cyc({n, "_decode"}, '0);
    endtask

    initial begin
        out_t e, hlt;
        RST = 1'b1; wd_rst = 1'b1; zero = 1'b0; ihit = 1'b1; wd_ihit = 1'b0;
        dhit = 1'b0; link_inv = 1'b0; opcode = OP_RTYPE; funct = FN_ADD;
        cyc("reset", '0);
        RST = 1'b0;

        // ADD r3,r1,r2
        fd("add", OP_RTYPE, FN_ADD);
        cyc("add_exec", alu(ALU_ADD, 2'b00, 1'b0));
        e = alu(ALU_ADD, 2'b00, 1'b0); e.regwr = 1'b1; e.regdst = 2'b01;
        cyc("add_wb", e);

        // ADDI: sign-extended immediate
        fd("addi", OP_ADDI, 6'h00);
        cyc("addi_exec", alu(ALU_ADD, 2'b10, 1'b1));
        e = alu(ALU_ADD, 2'b10, 1'b1); e.regwr = 1'b1;
        cyc("addi_wb", e);

        // LW with dhit arriving on the sixth MEM cycle
        fd("lw", OP_LW, 6'h00);
        cyc("lw_addr", alu(ALU_ADD, 2'b10, 1'b1));
        for (int i = 0; i < 6; i++) begin
            dhit = (i == 5);
            e = alu(ALU_ADD, 2'b10, 1'b1); e.dren = 1'b1;
            cyc($sformatf("lw_mem%0d", i), e);
        end
        dhit = 1'b0;
        e = '0; e.regwr = 1'b1; e.mem2reg = 1'b1;
        cyc("lw_wb", e);

        // Branches and JAL
        zero = 1'b0;
        fd("bne", OP_BNE, 6'h00);
        e = alu(ALU_SUB, 2'b00, 1'b0); e.pcsrc = 1'b1; e.pcwr = 1'b1;
        cyc("bne_branch", e);
        fd("beq0", OP_BEQ, 6'h00);
        cyc("beq0_branch", alu(ALU_SUB, 2'b00, 1'b0));
        zero = 1'b1;
        fd("beq1", OP_BEQ, 6'h00);
        e = alu(ALU_SUB, 2'b00, 1'b0); e.pcsrc = 1'b1; e.pcwr = 1'b1;
        cyc("beq1_branch", e);
        zero = 1'b0;
        fd("jal", OP_JAL, 6'h00);
        e = '0; e.pcwr = 1'b1; e.jump = 1'b1; e.jal = 1'b1; e.regwr = 1'b1; e.regdst = 2'b10;
        cyc("jal_jump", e);

        // LL then SC, no invalidate: store happens and succeeds
        for (int k = 0; k < 2; k++) begin
            fd($sformatf("ll%0d", k), OP_LL, 6'h00);
            cyc($sformatf("ll%0d_addr", k), alu(ALU_ADD, 2'b10, 1'b1));
            dhit = 1'b1;
            e = alu(ALU_ADD, 2'b10, 1'b1); e.dren = 1'b1;
            cyc($sformatf("ll%0d_mem", k), e);
            dhit = 1'b0;
            e = '0; e.regwr = 1'b1; e.mem2reg = 1'b1;
            cyc($sformatf("ll%0d_wb", k), e);

            // Second pass: snoop invalidate while the SC is being fetched
            opcode = OP_SC;
            link_inv = (k == 1);
            cyc($sformatf("sc%0d_fetch", k), fetch_hit());
            link_inv = 1'b0;
            cyc($sformatf("sc%0d_decode", k), '0);
            cyc($sformatf("sc%0d_addr", k), alu(ALU_ADD, 2'b10, 1'b1));
            dhit = (k == 0);
            e = alu(ALU_ADD, 2'b10, 1'b1); e.dwen = (k == 0);
            cyc($sformatf("sc%0d_mem", k), e);
            dhit = 1'b0;
            e = '0; e.regwr = 1'b1; e.sc_wr = 1'b1; e.sc_ok = (k == 0);
            cyc($sformatf("sc%0d_wb", k), e);
        end

        // Unused opcode decodes as illegal, becomes a NOP
        opcode = 6'b010000;
        cyc("ill_fetch", fetch_hit());
        e = '0; e.illegal = 1'b1;
        cyc("ill_decode", e);

        // HALT is absorbing
        fd("halt", OP_HALT, 6'h00);
        hlt = '0; hlt.halt = 1'b1;
        cyc("halt_0", hlt);
        cyc("halt_1", hlt);

        // Watchdog instance: four unacked fetch cycles trip the error halt
        wd_rst = 1'b0;
        for (int i = 0; i < 4; i++) wcyc($sformatf("wd_wait%0d", i), hlt, 1'b1, 1'b0, 1'b0);
        wcyc("wd_trip0", hlt, 1'b0, 1'b1, 1'b1);
        wcyc("wd_trip1", hlt, 1'b0, 1'b1, 1'b1);
        wd_rst = 1'b1;
        wcyc("wd_rst", hlt, 1'b0, 1'b0, 1'b0);
        wd_rst = 1'b0;
        for (int i = 0; i < 3; i++) wcyc($sformatf("wd_resume%0d", i), hlt, 1'b1, 1'b0, 1'b0);
        // Hit on the limit cycle wins over the watchdog
        wd_ihit = 1'b1;
        wcyc("wd_hit_at_limit", hlt, 1'b1, 1'b0, 1'b0);
        wcyc("wd_decode", hlt, 1'b0, 1'b0, 1'b0);
        wcyc("wd_halt_op", hlt, 1'b0, 1'b1, 1'b0);

        // Single-cycle reset releases the main halt and resumes fetching
        RST = 1'b1; ihit = 1'b0;
        cyc("halt_rst", '0);
        RST = 1'b0;
        e = '0; e.iren = 1'b1;
        cyc("post_rst_fetch", e);

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
